// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO accumulator.
// Optional MULDIV_DIVZERO_EARLY_EN: divide by zero skips the iteration and raises DivByZero.
module hilo_muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start,
    input  logic [1:0]      Op,
    input  logic [ITER-1:0] A,
    input  logic [ITER-1:0] B,
    input  logic            HiWe,
    input  logic            LoWe,
    input  logic [ITER-1:0] WrData,
    output logic            Busy,
    output logic            Done,
    output logic [ITER-1:0] Hi,
    output logic [ITER-1:0] Lo,
    output logic            DivByZero
);
`ifdef MULDIV_DIVZERO_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int CW = $clog2(ITER);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0] op;
    logic sign_a, sign_b, dz, dz_flag, in_signed, in_dz, ge, flip;
    logic [ITER-1:0] a_raw, bm, a_mag, b_mag, hi_fix, lo_fix;
    logic [2*ITER-1:0] acc, acc_step, acc_neg;
    logic [ITER:0] msum, rsh;

    assign in_signed = ~Op[0];
    assign in_dz = Op[1] && B == '0;
    assign a_mag = (in_signed && A[ITER-1]) ? -A : A;
    assign b_mag = (in_signed && B[ITER-1]) ? -B : B;
    // acc holds {carry-free product} for multiply and {rem, quo} for divide
    assign msum = {1'b0, acc[2*ITER-1:ITER]} + (acc[0] ? {1'b0, bm} : '0);
    assign rsh = {acc[2*ITER-1:ITER], acc[ITER-1]};
    assign ge = rsh >= {1'b0, bm};
    assign acc_step = op[1] ? {ge ? rsh[ITER-1:0] - bm : rsh[ITER-1:0], acc[ITER-2:0], ge}
                            : {msum, acc[ITER-1:1]};
    assign acc_neg = -acc;
    assign flip = ~op[0] && (sign_a ^ sign_b);
    // remainder follows the dividend sign; quotient and product follow signA^signB
    assign hi_fix = dz ? a_raw
                  : op[1] ? ((~op[0] && sign_a) ? -acc[2*ITER-1:ITER] : acc[2*ITER-1:ITER])
                  : (flip ? acc_neg[2*ITER-1:ITER] : acc[2*ITER-1:ITER]);
    assign lo_fix = dz ? '1 : flip ? acc_neg[ITER-1:0] : acc[ITER-1:0];
    assign DivByZero = dz_flag;

    always_comb begin
        state_nx = state;
        Busy = state == RUN || state == FIX;
        Done = state == DONE;
        if (state == IDLE) state_nx = Start ? ((EARLY && in_dz) ? FIX : RUN) : IDLE;
        else if (state == RUN) state_nx = (cnt == CW'(ITER - 1)) ? FIX : RUN;
        else state_nx = (state == FIX) ? DONE : IDLE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= '0;
            Hi <= '0;
            Lo <= '0;
            dz_flag <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && Start) begin
                op <= Op;
                sign_a <= in_signed && A[ITER-1];
                sign_b <= in_signed && B[ITER-1];
                a_raw <= A;
                bm <= b_mag;
                acc <= {{ITER{1'b0}}, a_mag};
                dz <= in_dz;
                cnt <= '0;
                dz_flag <= 1'b0;
            end else if (state == IDLE) begin
                if (HiWe) Hi <= WrData;
                if (LoWe) Lo <= WrData;
            end
            if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                Hi <= hi_fix;
                Lo <= lo_fix;
                dz_flag <= EARLY && dz;
            end
        end
    end
endmodule
